// File: rtl/du_lod_arbiter.sv
// Round-robin shared leading-one detector / normalizer for the GELU divider.
// Each request is accepted, normalized, and answered before the next request is taken.

module du_lod #(
  parameter int W  = 64,
  parameter int SW = 6
) (
  input  logic [W-1:0]  op_i,
  output logic [SW-1:0] pos_o,
  output logic          zero_o
);

  always_comb begin
    pos_o = '0;
    for (int i = 0; i < W; i++) begin
      if (op_i[i]) pos_o = SW'(i);
    end
    zero_o = (op_i == '0);
  end

endmodule

// state | meaning
// IDLE  | offer a round-robin grant and capture the operand on handshake
// CALC  | run the LOD on the captured operand and register the result
// RESP  | present the result until the consumer takes it
module du_lod_arbiter #(
  parameter int W     = 64,
  parameter int FRAC  = 16,
  parameter int N_REQ = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*W-1:0]           req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(N_REQ)-1:0]     rsp_id,
  output logic [W-1:0]                 rsp_norm,
  output logic [$clog2(W)-1:0]         rsp_shift,
  output logic [$clog2(W):0]           rsp_exp,
  output logic                         rsp_zero,
  output logic                         busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int SW  = $clog2(W);
  localparam int EW  = SW + 1;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [W-1:0]     op_q, op_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [W-1:0]     rsp_norm_q, rsp_norm_d;
  logic [SW-1:0]    rsp_shift_q, rsp_shift_d;
  logic [EW-1:0]    rsp_exp_q, rsp_exp_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic             grant_valid;
  logic [IDW-1:0]   grant_idx;
  logic [W-1:0]     op_sel;
  logic             hs;
  logic [SW-1:0]    lod_pos;
  logic             lod_zero;
  logic [SW-1:0]    shift_amt;
  int               cand;

  du_lod #(.W(W), .SW(SW)) u_lod (
    .op_i   (op_q),
    .pos_o  (lod_pos),
    .zero_o (lod_zero)
  );

  // Search starts one past the last winner so a held request cannot starve.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % N_REQ;
      if (!grant_valid && req_valid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

  always_comb begin
    op_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDW'(i)) op_sel = req_data[i*W +: W];
    end
  end

  // Gated by rst_n so no accept is advertised while reset is held.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_valid && rst_n) req_ready[grant_idx] = 1'b1;
  end

  assign hs        = |(req_valid & req_ready);
  assign shift_amt = SW'(W - 1) - lod_pos;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_d        = op_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_norm_d  = rsp_norm_q;
    rsp_shift_d = rsp_shift_q;
    rsp_exp_d   = rsp_exp_q;
    rsp_zero_d  = rsp_zero_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          op_d     = op_sel;
          id_d     = grant_idx;
          rr_ptr_d = grant_idx;
          state_d  = CALC;
        end
      end
      CALC: begin
        rsp_id_d = id_q;
        if (lod_zero) begin
          rsp_norm_d  = '0;
          rsp_shift_d = '0;
          rsp_exp_d   = '0;
          rsp_zero_d  = 1'b1;
        end else begin
          rsp_norm_d  = op_q << shift_amt;
          rsp_shift_d = shift_amt;
          rsp_exp_d   = {1'b0, lod_pos} - EW'(FRAC);
          rsp_zero_d  = 1'b0;
        end
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IDW'(N_REQ - 1);
      op_q        <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_norm_q  <= '0;
      rsp_shift_q <= '0;
      rsp_exp_q   <= '0;
      rsp_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_norm_q  <= rsp_norm_d;
      rsp_shift_q <= rsp_shift_d;
      rsp_exp_q   <= rsp_exp_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_norm  = rsp_norm_q;
  assign rsp_shift = rsp_shift_q;
  assign rsp_exp   = rsp_exp_q;
  assign rsp_zero  = rsp_zero_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/du_lod_arbiter.md
Name: du_lod_arbiter

Overview:
Shares one leading-one-detector/normalizer between N_REQ requesters of the GELU division unit, typically the numerator and denominator paths. Arbitration is round-robin. The accepted operand is registered, its MSB '1' is located with the LOD module (one instance), and the block returns a left-normalized value plus an unbiased exponent for the Q(W-FRAC).FRAC format. Results return through a valid/ready response channel tagged with the requester id.

Parameters:
W, 64, operand width (Q48.16 default).
FRAC, 16, fractional bits of the operand format.
N_REQ, 2, number of requesters (>=2).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  N_REQ  per-requester operand valid.
req_data  in  N_REQ*W  packed operands; requester i at bits [i*W +: W].
req_ready  out  N_REQ  one-hot (or zero) accept; high only for the granted requester.
rsp_valid  out  1  result valid.
rsp_ready  in  1  consumer accepts result.
rsp_id  out  $clog2(N_REQ)  index of the requester owning the result.
rsp_norm  out  W  operand << (W-1-lod_pos); MSB set unless zero.
rsp_shift  out  $clog2(W)  left-shift applied, W-1-lod_pos.
rsp_exp  out  $clog2(W)+1  signed, lod_pos - FRAC.
rsp_zero  out  1  operand was zero.
busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; rr_ptr=N_REQ-1, so requester 0 has first priority; rsp_valid=0; req_ready=0; rsp_id/rsp_norm/rsp_shift/rsp_exp/rsp_zero=0; busy=0.
- FSM states:
  - IDLE:
    - grant = first i with req_valid[i], searching rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
    - req_ready[grant]=1 combinationally; all other req_ready bits are 0.
    - On handshake (req_valid[g] & req_ready[g]): capture op_reg<=req_data[g], id_reg<=g, rr_ptr<=g; go to CALC.
    - No valid requester: stay in IDLE.
  - CALC:
    - req_ready=0.
    - LOD operates on op_reg.
    - Register rsp_norm, rsp_shift, rsp_exp, rsp_zero, and rsp_id<=id_reg; go to RESP.
  - RESP:
    - rsp_valid=1; all rsp_* outputs held stable.
    - On rsp_ready=1: rsp_valid<=0 and go to IDLE.
    - Otherwise hold indefinitely.
- Latency: handshake at edge t gives rsp_valid=1 from edge t+2. Minimum initiation interval is 3 cycles (accept, calc, response with rsp_ready=1), then IDLE.
- Zero operand: rsp_zero=1, rsp_norm=0, rsp_shift=0, rsp_exp=0.
- Arithmetic: the shift is a logical left shift with W-bit result (no bits lost, because the shift is exactly the number of leading zeros). rsp_exp is sign-extended two's complement, range -FRAC..W-1-FRAC.
- req_data of non-granted requesters is ignored. A requester that drops req_valid before the handshake loses nothing, and the grant recomputes every IDLE cycle.
- Simultaneous requests: exactly one is granted per IDLE visit. A requester holding req_valid continuously is served at least once every N_REQ accepts (no starvation).
- rsp_ready asserted outside RESP is ignored.
- Reset asserted in any state: immediate return to reset values. An in-flight operand is discarded and no response is issued.

Test Plan:
1. Req0 sends 0x0000_0000_0001_0000 (1.0) -> after 2 cycles, rsp_valid=1 with rsp_id=0, rsp_norm=0x8000_0000_0000_0000, rsp_shift=47, rsp_exp=0, rsp_zero=0.
2. Req1 sends 0x0000_0000_0000_0003 -> rsp_id=1, rsp_norm=0xC000_0000_0000_0000, rsp_shift=62, rsp_exp=-15; then send 0x8000_0000_0000_0000 -> rsp_shift=0, rsp_exp=47.
3. Req0 sends 0 -> rsp_zero=1, rsp_norm=0, rsp_shift=0, rsp_exp=0.
4. After reset, req0 and req1 both held valid continuously with rsp_ready=1 -> accepts alternate 0,1,0,1; req_ready is never high for both; each accept is spaced 3 cycles apart.
5. rsp_ready held low for 5 cycles in RESP -> rsp_valid and all rsp_* stay constant, req_ready=0 throughout, busy=1; rsp_ready=1 -> rsp_valid falls next edge and busy falls.
6. Assert rst_n=0 during CALC -> outputs return to reset values immediately; after release, a new req1 operand alone is accepted and its response carries rsp_id=1 with no stale result.
